// File: rtl/mm_test_pkg.sv
// Shared constants for the TPM management-module test sequencer: op-state codes,
// TPM response codes, the "don't compare state" marker and the sequencer state encoding.
package mm_test_pkg;

    localparam logic [2:0] OP_POWER_OFF   = 3'd0;
    localparam logic [2:0] OP_INITIALIZED = 3'd1;
    localparam logic [2:0] OP_STARTUP     = 3'd2;
    localparam logic [2:0] OP_OPERATIONAL = 3'd3;
    localparam logic [2:0] OP_SELF_TEST   = 3'd4;
    localparam logic [2:0] OP_FAILURE     = 3'd5;
    localparam logic [2:0] OP_SHUTDOWN    = 3'd6;

    localparam logic [2:0] ST_DONTCARE    = 3'b111;

    localparam logic [31:0] TPM_RC_SUCCESS    = 32'h0000_0000;
    localparam logic [31:0] TPM_RC_BAD_TAG    = 32'h0000_001E;
    localparam logic [31:0] TPM_RC_INITIALIZE = 32'h0000_0100;
    localparam logic [31:0] TPM_RC_FAILURE    = 32'h0000_0101;

    localparam logic [2:0] SEQ_IDLE      = 3'd0;
    localparam logic [2:0] SEQ_FETCH     = 3'd1;
    localparam logic [2:0] SEQ_LOAD      = 3'd2;
    localparam logic [2:0] SEQ_FIRE      = 3'd3;
    localparam logic [2:0] SEQ_SETTLE    = 3'd4;
    localparam logic [2:0] SEQ_CHECK     = 3'd5;
    localparam logic [2:0] SEQ_WAIT_STEP = 3'd6;
    localparam logic [2:0] SEQ_DONE      = 3'd7;

    // A vector passes when the response code matches and the state matches or is masked.
    function automatic logic vector_passes(input logic [31:0] rc, input logic [31:0] exp_rc,
                                           input logic [2:0] st, input logic [2:0] exp_st);
        return (rc == exp_rc) && ((exp_st == ST_DONTCARE) || (st == exp_st));
    endfunction

endpackage

// File: rtl/mm_vector_sequencer_if.sv
// Vector-table read port and management-module command/response bus of the sequencer.
interface mm_vector_sequencer_if #(
    parameter int NUM_VECTORS = 16
);
    localparam int AW = $clog2(NUM_VECTORS);

    logic          vec_rd;
    logic [AW-1:0] vec_addr;
    logic [31:0]   vec_cc;
    logic [32:0]   vec_param;
    logic [31:0]   vec_exp_rc;
    logic [2:0]    vec_exp_state;

    logic [31:0]   dut_cc;
    logic [32:0]   dut_param;
    logic          dut_start_n;
    logic [31:0]   dut_rc;
    logic [2:0]    dut_state;

    modport master (
        output vec_rd, vec_addr, dut_cc, dut_param, dut_start_n,
        input  vec_cc, vec_param, vec_exp_rc, vec_exp_state, dut_rc, dut_state
    );

    modport slave (
        input  vec_rd, vec_addr, dut_cc, dut_param, dut_start_n,
        output vec_cc, vec_param, vec_exp_rc, vec_exp_state, dut_rc, dut_state
    );
endinterface

// File: rtl/mm_vector_sequencer.sv
// Walks the command-vector table, fires each vector into the management module,
// and scores the returned response code / op-state against the expected values.
module mm_vector_sequencer
    import mm_test_pkg::*;
#(
    parameter int  NUM_VECTORS   = 16,
    parameter int  SETTLE_CYCLES = 8,
    localparam int AW            = $clog2(NUM_VECTORS),
    localparam int CW            = $clog2(NUM_VECTORS + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    mm_vector_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        cur_idx,
    output logic [CW-1:0]        pass_count,
    output logic [CW-1:0]        fail_count,
    output logic                 first_fail_vld,
    output logic [AW-1:0]        first_fail_idx
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [SW-1:0] settle_cnt;
    logic [31:0]   exp_rc;
    logic [2:0]    exp_state;
    logic [31:0]   cc_q;
    logic [32:0]   param_q;

    // NOTE: strobes are decoded straight from the registered state; no latch, and they
    // take their reset values the moment reset_n falls.
    assign bus.vec_rd      = (state == SEQ_FETCH);
    assign bus.vec_addr    = idx;
    assign bus.dut_start_n = (state != SEQ_FIRE);
    assign bus.dut_cc      = cc_q;
    assign bus.dut_param   = param_q;

    assign busy    = (state != SEQ_IDLE) && (state != SEQ_DONE);
    assign done    = (state == SEQ_DONE);
    assign cur_idx = idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= SEQ_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            exp_rc         <= '0;
            exp_state      <= '0;
            cc_q           <= '0;
            param_q        <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (start) begin
                        pass_count     <= '0;
                        fail_count     <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        idx            <= '0;
                        state          <= SEQ_FETCH;
                    end
                end
                SEQ_FETCH: state <= SEQ_LOAD;
                SEQ_LOAD: begin
                    cc_q      <= bus.vec_cc;
                    param_q   <= bus.vec_param;
                    exp_rc    <= bus.vec_exp_rc;
                    exp_state <= bus.vec_exp_state;
                    state     <= SEQ_FIRE;
                end
                SEQ_FIRE: begin
                    settle_cnt <= '0;
                    state      <= SEQ_SETTLE;
                end
                SEQ_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state <= SEQ_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SEQ_CHECK: begin
                    if (vector_passes(bus.dut_rc, exp_rc, bus.dut_state, exp_state)) begin
                        if (pass_count != CW'(NUM_VECTORS)) pass_count <= pass_count + 1'b1;
                    end else begin
                        if (fail_count != CW'(NUM_VECTORS)) fail_count <= fail_count + 1'b1;
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx == AW'(NUM_VECTORS - 1)) begin
                        state <= SEQ_DONE;
                    end else if (step_mode) begin
                        state <= SEQ_WAIT_STEP;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SEQ_FETCH;
                    end
                end
                SEQ_WAIT_STEP: begin
                    // Dropping step_mode while paused resumes the run without a step pulse.
                    if (step || !step_mode) begin
                        idx   <= idx + 1'b1;
                        state <= SEQ_FETCH;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_vector_sequencer.sv
// Randomised and directed bench for mm_vector_sequencer with a behavioural vector table
// and a stand-in management module that answers each start strobe.
module tb_mm_vector_sequencer;
    import mm_test_pkg::*;

    localparam int NV         = 3;
    localparam int SETTLE     = 8;
    localparam int AW         = $clog2(NV);
    localparam int CW         = $clog2(NV + 1);
    localparam int RUN_CYCLES = NV * (SETTLE + 4);

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic step_mode = 1'b0;
    logic step = 1'b0;
    logic busy, done, first_fail_vld;
    logic [AW-1:0] cur_idx, first_fail_idx;
    logic [CW-1:0] pass_count, fail_count;

    int checks = 0;
    int failures = 0;

    mm_vector_sequencer_if #(.NUM_VECTORS(NV)) bus ();

    mm_vector_sequencer #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .step_mode      (step_mode),
        .step           (step),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .cur_idx        (cur_idx),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
    );

    always #10 clock = ~clock;

    logic [31:0] tbl_cc    [NV];
    logic [32:0] tbl_param [NV];
    logic [31:0] tbl_rc    [NV];
    logic [2:0]  tbl_state [NV];
    logic [31:0] resp_rc   [4];
    logic [2:0]  resp_state[4];
    int          fire_count = 0;

    // Synchronous-read vector table.
    always @(posedge clock) begin
        if (bus.vec_rd) begin
            bus.vec_cc        <= tbl_cc[bus.vec_addr];
            bus.vec_param     <= tbl_param[bus.vec_addr];
            bus.vec_exp_rc    <= tbl_rc[bus.vec_addr];
            bus.vec_exp_state <= tbl_state[bus.vec_addr];
        end
    end

    // Stand-in management module: the low command-code bits name the vector it answers.
    always @(posedge clock) begin
        if (!bus.dut_start_n) begin
            bus.dut_rc    <= resp_rc[bus.dut_cc[1:0]];
            bus.dut_state <= resp_state[bus.dut_cc[1:0]];
            fire_count    <= fire_count + 1;
        end
    end

    // mode 0 random, 1 all match, 2 vector 1 rc mismatch, 3 state masked but different
    task automatic fill_table(input int mode);
        logic [31:0] r;
        for (int i = 0; i < NV; i++) begin
            r = $urandom();
            tbl_cc[i]    = {r[31:2], 2'(i)};
            tbl_param[i] = {1'($urandom_range(0, 1)), 32'($urandom())};
            tbl_rc[i]    = ($urandom_range(0, 3) == 0) ? TPM_RC_SUCCESS : 32'($urandom());
            tbl_state[i] = 3'($urandom_range(0, 7));
            resp_rc[i]   = tbl_rc[i];
            resp_state[i] = (tbl_state[i] == ST_DONTCARE) ? 3'($urandom_range(0, 6)) : tbl_state[i];
            if (mode == 0) begin
                if ($urandom_range(0, 2) == 0) resp_rc[i] = tbl_rc[i] ^ (32'h1 << $urandom_range(0, 31));
                if ($urandom_range(0, 2) == 0 && tbl_state[i] != ST_DONTCARE)
                    resp_state[i] = tbl_state[i] ^ 3'($urandom_range(1, 7));
            end else if (mode == 2 && i == 1) begin
                tbl_rc[i]  = TPM_RC_SUCCESS;
                resp_rc[i] = TPM_RC_FAILURE;
            end else if (mode == 3) begin
                tbl_state[i]  = ST_DONTCARE;
                resp_state[i] = (i == 0) ? OP_SHUTDOWN : OP_FAILURE;
            end
        end
    endtask

    task automatic expected_scores(output int ep, output int ef, output bit efv, output int efi);
        ep = 0; ef = 0; efv = 0; efi = 0;
        for (int i = 0; i < NV; i++) begin
            if (resp_rc[i] == tbl_rc[i] && (tbl_state[i] == ST_DONTCARE || resp_state[i] == tbl_state[i])) begin
                ep++;
            end else begin
                if (!efv) begin efv = 1; efi = i; end
                ef++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, cur_idx, pass_count, fail_count, first_fail_vld, first_fail_idx} !== '0) begin
            failures++;
            $display("FAIL reset_status: got %0h expected 0",
                     {busy, done, cur_idx, pass_count, fail_count, first_fail_vld, first_fail_idx});
        end
        checks++;
        if ({bus.vec_rd, bus.vec_addr, bus.dut_cc, bus.dut_param} !== '0) begin
            failures++;
            $display("FAIL reset_bus: got %0h expected 0", {bus.vec_rd, bus.vec_addr, bus.dut_cc, bus.dut_param});
        end
        checks++;
        if (bus.dut_start_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_start_n: got %b expected 1", bus.dut_start_n);
        end
    endtask

    task automatic test_all_match();
        int cyc, f0;
        fill_table(1);
        f0 = fire_count;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != RUN_CYCLES) begin failures++; $display("FAIL all_match_latency: got %0d expected %0d", cyc, RUN_CYCLES); end
        repeat (5) @(negedge clock);
        checks++;
        if ({done, busy, pass_count, fail_count, first_fail_vld} !== {1'b1, 1'b0, CW'(NV), CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL all_match_result: got done=%b busy=%b pass=%0d fail=%0d ffv=%b expected 1 0 %0d 0 0",
                     done, busy, pass_count, fail_count, first_fail_vld, NV);
        end
        checks++;
        if (fire_count - f0 != NV) begin failures++; $display("FAIL all_match_fires: got %0d expected %0d", fire_count - f0, NV); end
    endtask

    task automatic test_rc_mismatch();
        int cyc;
        fill_table(2);
        pulse_start();
        wait_done(cyc);
        checks++;
        if ({pass_count, fail_count, first_fail_vld, first_fail_idx} !== {CW'(NV - 1), CW'(1), 1'b1, AW'(1)}) begin
            failures++;
            $display("FAIL rc_mismatch: got pass=%0d fail=%0d ffv=%b ffi=%0d expected %0d 1 1 1",
                     pass_count, fail_count, first_fail_vld, first_fail_idx, NV - 1);
        end
    endtask

    task automatic test_restart_clears();
        int cyc;
        fill_table(1);
        pulse_start();
        checks++;
        if ({busy, done, pass_count, fail_count, first_fail_vld, cur_idx} !== {1'b1, 1'b0, CW'(0), CW'(0), 1'b0, AW'(0)}) begin
            failures++;
            $display("FAIL restart_clear: got busy=%b done=%b pass=%0d fail=%0d ffv=%b idx=%0d expected 1 0 0 0 0 0",
                     busy, done, pass_count, fail_count, first_fail_vld, cur_idx);
        end
        wait_done(cyc);
        checks++;
        if (pass_count !== CW'(NV) || cyc != RUN_CYCLES) begin
            failures++;
            $display("FAIL restart_run: got pass=%0d cycles=%0d expected %0d %0d", pass_count, cyc, NV, RUN_CYCLES);
        end
    endtask

    task automatic test_dontcare();
        int cyc;
        fill_table(3);
        pulse_start();
        wait_done(cyc);
        checks++;
        if ({pass_count, fail_count} !== {CW'(NV), CW'(0)}) begin
            failures++;
            $display("FAIL dontcare: got pass=%0d fail=%0d expected %0d 0", pass_count, fail_count, NV);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        fill_table(2);
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            start = (cyc == 15);
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc != RUN_CYCLES || {pass_count, fail_count} !== {CW'(NV - 1), CW'(1)}) begin
            failures++;
            $display("FAIL start_ignored: got cycles=%0d pass=%0d fail=%0d expected %0d %0d 1",
                     cyc, pass_count, fail_count, RUN_CYCLES, NV - 1);
        end
    endtask

    task automatic test_step_mode();
        int cyc;
        fill_table(1);
        step_mode = 1'b1;
        pulse_start();
        repeat (20) @(negedge clock);
        checks++;
        if ({busy, cur_idx, pass_count} !== {1'b1, AW'(0), CW'(1)}) begin
            failures++;
            $display("FAIL step_pause0: got busy=%b idx=%0d pass=%0d expected 1 0 1", busy, cur_idx, pass_count);
        end
        pulse_step();
        checks++;
        if (cur_idx !== AW'(1)) begin failures++; $display("FAIL step_advance: got idx=%0d expected 1", cur_idx); end
        repeat (4) @(negedge clock);
        pulse_step();
        repeat (15) @(negedge clock);
        checks++;
        if ({busy, cur_idx, pass_count} !== {1'b1, AW'(1), CW'(2)}) begin
            failures++;
            $display("FAIL step_pause1: got busy=%b idx=%0d pass=%0d expected 1 1 2", busy, cur_idx, pass_count);
        end
        start = 1'b1;
        pulse_step();
        start = 1'b0;
        checks++;
        if ({busy, cur_idx, pass_count} !== {1'b1, AW'(2), CW'(2)}) begin
            failures++;
            $display("FAIL step_with_start: got busy=%b idx=%0d pass=%0d expected 1 2 2", busy, cur_idx, pass_count);
        end
        wait_done(cyc);
        checks++;
        if (cyc != SETTLE + 4 || pass_count !== CW'(NV)) begin
            failures++;
            $display("FAIL step_last: got cycles=%0d pass=%0d expected %0d %0d", cyc, pass_count, SETTLE + 4, NV);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_step_resume();
        int cyc;
        fill_table(1);
        step_mode = 1'b1;
        pulse_start();
        repeat (20) @(negedge clock);
        step_mode = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 2 * (SETTLE + 4) + 1 || pass_count !== CW'(NV)) begin
            failures++;
            $display("FAIL step_resume: got cycles=%0d pass=%0d expected %0d %0d", cyc, pass_count, 2 * (SETTLE + 4) + 1, NV);
        end
    endtask

    task automatic test_random_runs();
        int cyc, f0, ep, ef, efi;
        bit efv;
        for (int run = 0; run < 12; run++) begin
            fill_table(0);
            expected_scores(ep, ef, efv, efi);
            f0 = fire_count;
            pulse_start();
            wait_done(cyc);
            checks++;
            if (cyc != RUN_CYCLES || pass_count !== CW'(ep) || fail_count !== CW'(ef) ||
                first_fail_vld !== efv || (efv && first_fail_idx !== AW'(efi))) begin
                failures++;
                $display("FAIL random_run%0d: got cycles=%0d pass=%0d fail=%0d ffv=%b ffi=%0d expected %0d %0d %0d %b %0d",
                         run, cyc, pass_count, fail_count, first_fail_vld, first_fail_idx,
                         RUN_CYCLES, ep, ef, efv, efi);
            end
            checks++;
            if (fire_count - f0 != NV || bus.dut_cc !== tbl_cc[NV - 1] || bus.dut_param !== tbl_param[NV - 1]) begin
                failures++;
                $display("FAIL random_drive%0d: got fires=%0d cc=%0h param=%0h expected %0d %0h %0h",
                         run, fire_count - f0, bus.dut_cc, bus.dut_param, NV, tbl_cc[NV - 1], tbl_param[NV - 1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        fill_table(2);
        pulse_start();
        repeat (17) @(negedge clock);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cur_idx, pass_count, fail_count, first_fail_vld, first_fail_idx,
             bus.vec_rd, bus.vec_addr, bus.dut_cc, bus.dut_param, bus.dut_start_n} !== {{(2 * AW + 2 * CW + 35 + 33){1'b0}}, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%b done=%b idx=%0d pass=%0d fail=%0d ffv=%b cc=%0h start_n=%b expected reset values",
                     busy, done, cur_idx, pass_count, fail_count, first_fail_vld, bus.dut_cc, bus.dut_start_n);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if ({busy, done, pass_count, fail_count} !== '0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b done=%b pass=%0d fail=%0d expected 0 0 0 0",
                     busy, done, pass_count, fail_count);
        end
    endtask

    initial begin
        fill_table(1);
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_all_match();
        test_rc_mismatch();
        test_restart_clears();
        test_dontcare();
        test_start_ignored();
        test_step_mode();
        test_step_resume();
        test_random_runs();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
